// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirects held across memory wait states, and misaligned-target handling.
// Optional macro FETCH_TRAP_EN: a misaligned redirect vectors to TRAP_VEC instead of halting fetch.
//
// state | meaning
// BOOT  | one idle cycle after reset, PCF = RESET_PC, no request
// FETCH | requesting PCF every cycle
// HALT  | stopped after a misaligned redirect, sticky until reset
// TRAP  | (FETCH_TRAP_EN) one idle cycle loading TRAP_VEC
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        PCEnF,
    output logic        InstrValidF,
    output logic        FlushD,
    output logic        MisalignF,
    output logic        Halted,
    output logic [31:0] FetchCnt
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
`ifdef FETCH_TRAP_EN
    localparam logic [1:0] S_TRAP  = 2'd3;
`endif

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_ctrl: RESET_PC must be word aligned");
    end
    if (TRAP_VEC[1:0] != 2'b00) begin : g_bad_trap_vec
        $error("fetch_ctrl: TRAP_VEC must be word aligned");
    end

    logic [1:0]  r_state;
    logic [31:0] r_pcf;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic [31:0] r_fetch_cnt;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pcf_nxt;
    logic        w_pend_valid_nxt;
    logic [31:0] w_pend_target_nxt;
    logic        w_cnt_inc;
    logic        w_pc_en;
    logic        w_instr_valid;
    logic        w_flush;
    logic        w_misalign;
    logic        w_tgt_misaligned;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4       = r_pcf + 32'd4;
    assign w_tgt_misaligned = (PCTargetE[1:0] != 2'b00);

    always_comb begin
        w_state_nxt       = r_state;
        w_pcf_nxt         = r_pcf;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_cnt_inc         = 1'b0;
        w_pc_en           = 1'b0;
        w_instr_valid     = 1'b0;
        w_flush           = 1'b0;
        w_misalign        = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (PCSrcE) begin
                    w_flush = 1'b1;
                    if (w_tgt_misaligned) begin
                        w_misalign       = 1'b1;
                        w_pend_valid_nxt = 1'b0;
`ifdef FETCH_TRAP_EN
                        w_state_nxt      = S_TRAP;
`else
                        w_state_nxt      = S_HALT;
`endif
                    end else if (imem_ready) begin
                        w_pcf_nxt        = PCTargetE;
                        w_pc_en          = 1'b1;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        // memory still busy with the old PCF: park the target until it answers
                        w_pend_target_nxt = PCTargetE;
                        w_pend_valid_nxt  = 1'b1;
                    end
                end else if (r_pend_valid) begin
                    if (imem_ready) begin
                        w_pcf_nxt        = r_pend_target;
                        w_pc_en          = 1'b1;
                        w_pend_valid_nxt = 1'b0;
                    end
                end else if (StallF) begin
                    w_instr_valid = imem_ready;
                end else if (imem_ready) begin
                    w_pcf_nxt     = w_pc_plus4;
                    w_pc_en       = 1'b1;
                    w_instr_valid = 1'b1;
                    w_cnt_inc     = 1'b1;
                end
            end
`ifdef FETCH_TRAP_EN
            S_TRAP: begin
                w_pcf_nxt   = TRAP_VEC;
                w_pc_en     = 1'b1;
                w_state_nxt = S_FETCH;
            end
`endif
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_BOOT;
            r_pcf         <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_fetch_cnt   <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pcf         <= w_pcf_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            if (w_cnt_inc) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign Halted      = (r_state == S_HALT);
    assign PCF         = r_pcf;
    assign PCPlus4F    = w_pc_plus4;
    assign PCEnF       = w_pc_en;
    assign InstrValidF = w_instr_valid;
    assign FlushD      = w_flush;
    assign MisalignF   = w_misalign;
    assign FetchCnt    = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; expectations follow FETCH_TRAP_EN when that macro is defined.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        PCEnF;
    logic        InstrValidF;
    logic        FlushD;
    logic        MisalignF;
    logic        Halted;
    logic [31:0] FetchCnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .PCEnF      (PCEnF),
        .InstrValidF(InstrValidF),
        .FlushD     (FlushD),
        .MisalignF  (MisalignF),
        .Halted     (Halted),
        .FetchCnt   (FetchCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0; imem_ready = 1'b1;
        tick(); tick();
        #1;
        chk("rst_pcf",    PCF, 32'h0);
        chk("rst_req",    32'(imem_req), 0);
        chk("rst_pcen",   32'(PCEnF), 0);
        chk("rst_ivalid", 32'(InstrValidF), 0);
        chk("rst_flush",  32'(FlushD), 0);
        chk("rst_mis",    32'(MisalignF), 0);
        chk("rst_halt",   32'(Halted), 0);
        chk("rst_cnt",    FetchCnt, 0);

        // cycle 0: BOOT, then sequential fetch 0,4,8
        reset = 1'b0;
        #1;
        chk("boot_req",  32'(imem_req), 0);
        chk("boot_pcen", 32'(PCEnF), 0);
        tick(); #1;
        chk("f0_req",    32'(imem_req), 1);
        chk("f0_pcf",    PCF, 32'h0);
        chk("f0_pcen",   32'(PCEnF), 1);
        chk("f0_ivalid", 32'(InstrValidF), 1);
        chk("f0_plus4",  PCPlus4F, 32'h4);
        tick(); #1;
        chk("f1_pcf", PCF, 32'h4);
        chk("f1_cnt", FetchCnt, 1);
        tick();

        // stall at PCF=8 for three cycles
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pcf",    PCF, 32'h8);
            chk("stall_pcen",   32'(PCEnF), 0);
            chk("stall_cnt",    FetchCnt, 2);
            chk("stall_ivalid", 32'(InstrValidF), 1);
            tick();
        end
        StallF = 1'b0;
        #1;
        chk("unstall_pcf",  PCF, 32'h8);
        chk("unstall_pcen", 32'(PCEnF), 1);
        tick();

        // memory not ready, no redirect
        imem_ready = 1'b0;
        #1;
        chk("c_pcf",        PCF, 32'hC);
        chk("c_cnt",        FetchCnt, 3);
        chk("nordy_pcen",   32'(PCEnF), 0);
        chk("nordy_ivalid", 32'(InstrValidF), 0);
        tick(); #1;
        chk("nordy_hold", PCF, 32'hC);

        // redirect to 0x40 while memory busy
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        #1;
        chk("rd40_flush", 32'(FlushD), 1);
        chk("rd40_pcen",  32'(PCEnF), 0);
        chk("rd40_mis",   32'(MisalignF), 0);
        tick();
        PCSrcE = 1'b0;
        #1;
        chk("pend_flush", 32'(FlushD), 0);
        chk("pend_pcf",   PCF, 32'hC);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("pendrdy_pcf",    PCF, 32'hC);
        chk("pendrdy_ivalid", 32'(InstrValidF), 0);
        chk("pendrdy_pcen",   32'(PCEnF), 1);
        tick(); #1;
        chk("pcf40",   PCF, 32'h40);
        chk("cnt40",   FetchCnt, 3);
        tick(); #1;
        chk("pcf44",   PCF, 32'h44);
        chk("cnt44",   FetchCnt, 4);

        // pending 0x40 overwritten by 0x80; pending beats StallF
        imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h40;
        #1;
        chk("ow1_flush", 32'(FlushD), 1);
        tick();
        PCTargetE = 32'h80;
        #1;
        chk("ow2_flush", 32'(FlushD), 1);
        chk("ow2_pcf",   PCF, 32'h44);
        tick();
        PCSrcE = 1'b0; imem_ready = 1'b1; StallF = 1'b1;
        #1;
        chk("ow_pcen",   32'(PCEnF), 1);
        chk("ow_ivalid", 32'(InstrValidF), 0);
        tick();
        StallF = 1'b0;
        #1;
        chk("pcf80", PCF, 32'h80);
        chk("cnt80", FetchCnt, 4);
        tick(); #1;
        chk("pcf84", PCF, 32'h84);
        chk("cnt84", FetchCnt, 5);

        // redirect with ready wins over StallF
        PCSrcE = 1'b1; PCTargetE = 32'h200; StallF = 1'b1;
        #1;
        chk("rdst_flush",  32'(FlushD), 1);
        chk("rdst_pcen",   32'(PCEnF), 1);
        chk("rdst_ivalid", 32'(InstrValidF), 0);
        tick();
        PCSrcE = 1'b0; StallF = 1'b0;
        #1;
        chk("pcf200", PCF, 32'h200);
        chk("cnt200", FetchCnt, 5);

        // reset while a redirect is pending
        imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h300;
        tick();
        PCSrcE = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; imem_ready = 1'b1;
        #1;
        chk("prst_pcf", PCF, 32'h0);
        chk("prst_cnt", FetchCnt, 0);
        chk("prst_req", 32'(imem_req), 0);
        tick(); #1;
        chk("prst_f_pcf",    PCF, 32'h0);
        chk("prst_f_pcen",   32'(PCEnF), 1);
        chk("prst_f_ivalid", 32'(InstrValidF), 1);
        tick(); #1;
        chk("prst_pcf4", PCF, 32'h4);
        chk("prst_cnt1", FetchCnt, 1);

        // PC+4 wraps modulo 2^32
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 1'b0;
        #1;
        chk("wrap_pcf",   PCF, 32'hFFFF_FFFC);
        chk("wrap_plus4", PCPlus4F, 32'h0);
        tick(); #1;
        chk("wrap_pcf0", PCF, 32'h0);
        chk("wrap_cnt",  FetchCnt, 2);
        tick(); #1;
        chk("pre_mis_pcf", PCF, 32'h4);

        // misaligned redirect
        PCSrcE = 1'b1; PCTargetE = 32'h42;
        #1;
        chk("mis_pulse", 32'(MisalignF), 1);
        chk("mis_flush", 32'(FlushD), 1);
        chk("mis_pcen",  32'(PCEnF), 0);
        tick();
        PCSrcE = 1'b0;
        #1;
        chk("mis_end", 32'(MisalignF), 0);
`ifdef FETCH_TRAP_EN
        chk("trap_req",  32'(imem_req), 0);
        chk("trap_pcen", 32'(PCEnF), 1);
        chk("trap_halt", 32'(Halted), 0);
        chk("trap_pcf",  PCF, 32'h4);
        tick(); #1;
        chk("trap_vec",  PCF, 32'h100);
        chk("trap_req1", 32'(imem_req), 1);
        chk("trap_halt1", 32'(Halted), 0);
`else
        chk("halt_flag", 32'(Halted), 1);
        chk("halt_req",  32'(imem_req), 0);
        chk("halt_pcen", 32'(PCEnF), 0);
        chk("halt_pcf",  PCF, 32'h4);
        PCSrcE = 1'b1; PCTargetE = 32'h80;
        tick(); tick(); #1;
        chk("halt_sticky", 32'(Halted), 1);
        chk("halt_pcf2",   PCF, 32'h4);
        chk("halt_req2",   32'(imem_req), 0);
        chk("halt_ivalid", 32'(InstrValidF), 0);
        chk("halt_flush",  32'(FlushD), 0);
        chk("halt_cnt",    FetchCnt, 3);
        PCSrcE = 1'b0;
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("end_halt", 32'(Halted), 0);
        chk("end_pcf",  PCF, 32'h0);
        chk("end_cnt",  FetchCnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
